// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: FSM encoding, RV32I funct3 size codes,
// and the latched load/store descriptor.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int NUM_LANES = 4;
  localparam int TMO_W     = 10;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  typedef struct packed {
    logic       load;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
    logic [4:0] rd;
  } op_t;

  // funct3[2] is only the signedness bit; unknown sizes fall back to word
  function automatic size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: alignment check, store strobes / replicated write data,
// and load lane select with sign or zero extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic        misaligned,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  size_t       sz;
  logic [31:0] rshift;
  logic        sgn;

  assign sz         = f3_size(funct3);
  assign misaligned = (sz == SZ_H && addr_lo[0]) || (sz == SZ_W && addr_lo != 2'b00);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    assign wstrb[i] = (sz == SZ_B) ? (addr_lo == LANE) :
                      (sz == SZ_H) ? (addr_lo[1] == LANE[1]) : 1'b1;
    // data is replicated into every lane; the strobes pick the live ones
    assign wdata[8*i +: 8] = (sz == SZ_B) ? st_data[7:0] :
                             (sz == SZ_H) ? st_data[8*(i%2) +: 8] :
                                            st_data[8*i +: 8];
  end

  assign rshift = rdata >> {addr_lo, 3'b000};
  assign sgn    = ~funct3[2];

  always_comb begin
    ld_data = rshift;
    case (sz)
      SZ_B:    ld_data = {{24{rshift[7]  & sgn}}, rshift[7:0]};
      SZ_H:    ld_data = {{16{rshift[15] & sgn}}, rshift[15:0]};
      default: ld_data = rshift;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: one outstanding bus access, ack timeout, flush kill,
// single-cycle writeback for ALU ops and misaligned drops.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  state_t           state;
  op_t              op_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic             kill;

  logic             take, is_mem, dead;
  logic [2:0]       a_f3;
  logic [1:0]       a_lo;
  logic             a_mis;
  logic [3:0]       a_strb;
  logic [31:0]      a_wdata, a_ld;

  assign ex_ready = (state == S_IDLE);
  assign take     = ex_valid & ex_ready;
  assign is_mem   = ex_load | ex_store;
  assign dead     = kill | flush;

  // IDLE steers the incoming op for strobes; afterwards the latched op drives load extract
  assign a_f3 = (state == S_IDLE) ? ex_funct3    : op_q.funct3;
  assign a_lo = (state == S_IDLE) ? ex_addr[1:0] : op_q.addr_lo;

  mem_align u_align (
    .funct3     (a_f3),
    .addr_lo    (a_lo),
    .st_data    (ex_wdata),
    .rdata      (dmem_rdata),
    .misaligned (a_mis),
    .wstrb      (a_strb),
    .wdata      (a_wdata),
    .ld_data    (a_ld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      op_q       <= '0;
      tmo_cnt    <= '0;
      kill       <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wstrb <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          // a flushed op is simply not taken any further
          if (take && !flush) begin
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_we    <= (ex_rd != 5'd0);
              wb_rd    <= ex_rd;
              wb_data  <= ex_result;
            end else if (a_mis) begin
              misalign <= 1'b1;
              wb_valid <= 1'b1;
              wb_rd    <= ex_rd;
              wb_data  <= '0;
            end else begin
              op_q       <= '{load: ex_load, funct3: ex_funct3,
                              addr_lo: ex_addr[1:0], rd: ex_rd};
              dmem_req   <= 1'b1;
              dmem_we    <= ~ex_load;
              dmem_addr  <= {ex_addr[31:2], 2'b00};
              dmem_wstrb <= ex_load ? 4'b0000 : a_strb;
              dmem_wdata <= ex_load ? 32'd0   : a_wdata;
              tmo_cnt    <= '0;
              kill       <= 1'b0;
              state      <= S_REQ;
            end
          end
        end

        S_REQ: begin
          if (flush) kill <= 1'b1;
          // ack wins over a timeout landing in the same cycle
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            wb_valid <= ~dead;
            wb_we    <= op_q.load && (op_q.rd != 5'd0) && !dead;
            wb_rd    <= op_q.rd;
            wb_data  <= op_q.load ? a_ld : 32'd0;
            state    <= S_RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            dmem_req <= 1'b0;
            bus_err  <= 1'b1;
            wb_valid <= ~dead;
            wb_rd    <= op_q.rd;
            wb_data  <= '0;
            kill     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        S_RESP: begin
          kill  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
- REQ-001 SHALL have parameter ACK_TIMEOUT, default 255: maximum cycles to wait for dmem_ack, range 1..1023.
- REQ-002 SHALL have the following ports, one per line (name, direction, width, meaning):
  - clk  in  1  sole clock, rising edge.
  - rst  in  1  reset, asynchronous, active-low.
  - ex_valid  in  1  execute stage offers an op.
  - ex_ready  out  1  this stage accepts the op this cycle.
  - ex_load  in  1  op is a load.
  - ex_store  in  1  op is a store.
  - ex_funct3  in  3  RV32I size/sign field: 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - ex_addr  in  32  effective address.
  - ex_wdata  in  32  store data, right-aligned.
  - ex_rd  in  5  destination register.
  - ex_result  in  32  ALU result for non-memory ops.
  - flush  in  1  discard the op held or in flight.
  - dmem_req  out  1  bus request, held until ack.
  - dmem_we  out  1  bus write.
  - dmem_addr  out  32  word-aligned address, bits [1:0] = 00.
  - dmem_wstrb  out  4  byte strobes.
  - dmem_wdata  out  32  lane-shifted store data.
  - dmem_rdata  in  32  read data, valid with ack.
  - dmem_ack  in  1  one-cycle completion pulse.
  - wb_valid  out  1  writeback op valid, one cycle per op.
  - wb_we  out  1  register write enable.
  - wb_rd  out  5  destination register.
  - wb_data  out  32  writeback data.
  - misalign  out  1  one-cycle pulse: misaligned access dropped.
  - bus_err  out  1  one-cycle pulse: ack timeout.

Function
- REQ-003 SHALL implement FSM IDLE, REQ, RESP.
- REQ-004 In IDLE, ex_ready SHALL be 1. In REQ and RESP, ex_ready SHALL be 0.
- REQ-005 A non-memory op accepted in IDLE SHALL produce, next cycle: wb_valid=1, wb_we=(ex_rd!=0), wb_data=ex_result. FSM stays in IDLE.
- REQ-006 A load/store accepted in IDLE with correct alignment SHALL latch the op and go to REQ. dmem_req=1 from the next cycle until the cycle dmem_ack=1, inclusive.
- REQ-007 Alignment rule: H/HU need addr[0]=0; W needs addr[1:0]=00. A violating op SHALL assert misalign and wb_valid with wb_we=0 next cycle, issue no request, and stay in IDLE.
- REQ-008 Store strobes: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111. dmem_wdata is ex_wdata replicated into the addressed lanes.
- REQ-009 Load extract: select lane by addr[1:0]. B/H are sign-extended; BU/HU are zero-extended.
- REQ-010 On ack in REQ, the FSM SHALL go to RESP. The RESP cycle SHALL drive wb_valid=1 with: load → wb_we=(rd!=0) and extracted data; store → wb_we=0 and wb_data=0. Then return to IDLE.
- REQ-011 The timeout counter SHALL clear on entering REQ and increment each REQ cycle without ack. When it reaches ACK_TIMEOUT, the block SHALL deassert dmem_req, pulse bus_err, emit wb_valid with wb_we=0, and return to IDLE.
- REQ-012 ack arriving in the same cycle the counter reaches ACK_TIMEOUT SHALL count as success; no bus_err.
- REQ-013 flush in IDLE SHALL suppress the next-cycle wb_valid of an op accepted in that same cycle.
- REQ-014 flush in REQ SHALL NOT drop dmem_req; the bus transaction completes. A sticky kill bit forces wb_valid=0 in RESP.
- REQ-015 dmem_ack outside REQ SHALL be ignored.
- REQ-016 ex_load and ex_store both set SHALL be treated as a load.
- REQ-017 wb_rd=0 SHALL always give wb_we=0.

Reset
- REQ-018 With rst=0, the block SHALL asynchronously enter IDLE.
- REQ-019 During reset, all outputs SHALL be 0 except ex_ready=1; counter and kill bit SHALL be 0.
- REQ-020 Reset asserted in REQ SHALL abandon the transaction immediately; a later ack SHALL be ignored per REQ-015.

Structure
- REQ-021 A shared package SHALL hold the FSM state encoding and the funct3 size constants (B, H, W, BU, HU).
- REQ-022 Lane logic SHALL be one combinational sub-module, mem_align, covering strobe/wdata generation and load extract/extend; the FSM and counter stay in mem_stage.

Verification
- REQ-023 Load B, addr 0x1003, rdata 0x80FFFFFF, ack after 3 cycles: dmem_addr 0x1000; wb_data 0xFFFFFF80, wb_we=1.
- REQ-024 Store H, addr 0x2002, wdata 0x0000ABCD: dmem_wstrb 1100, dmem_wdata[31:16]=0xABCD, wb_we=0.
- REQ-025 Load W at addr 0x3001: misalign pulse, no dmem_req, wb_valid with wb_we=0.
- REQ-026 ACK_TIMEOUT=4, ack never comes: bus_err after 4 REQ cycles, dmem_req drops, ex_ready=1 next cycle.
- REQ-027 flush in the 2nd REQ cycle, ack in the 5th: dmem_req held through ack; no wb_valid.
- REQ-028 ALU op, rd=0, result 0x1234: wb_valid=1, wb_we=0, one-cycle latency.
